// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and clear engine
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we0,
  input  logic [AW-1:0]        waddr0,
  input  logic [DW-1:0]        wdata0,
  input  logic                 we1,
  input  logic [AW-1:0]        waddr1,
  input  logic [DW-1:0]        wdata1,
  input  logic [NUM_RD-1:0]    re,
  input  logic [NUM_RD*AW-1:0] raddr,
  output logic [NUM_RD*DW-1:0] rdata,
  input  logic                 clr_req,
  output logic                 ready
);

  // Sweep pointer width; DEPTH >= 2 keeps this at least one bit.
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_n;
  logic            ready_n;
  logic [DW-1:0]   regs [DEPTH];

  logic            commit;
  logic            w0_go;
  logic            w1_go;

  // An address is writable/readable only if it exists and is not the hard-wired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Array index; only called on addresses already known to be below DEPTH.
  function automatic logic [PW-1:0] idx(input logic [AW-1:0] a);
    idx = a[PW-1:0];
  endfunction

  // Port writes land only in RUN and never in the cycle a re-clear is requested.
  assign commit = rst && (state == RUN) && !clr_req;
  assign w1_go  = commit && we1 && addr_ok(waddr1);
  // Port 1 wins a same-address collision, so port 0 is suppressed there.
  assign w0_go  = commit && we0 && addr_ok(waddr0) && !(w1_go && (waddr0 == waddr1));

  // State register for the sweep/run controller.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      ready <= ready_n;
    end
  end

  // Next-state logic: walk ptr to the last entry, then run until a clear request.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    ready_n = ready;
    case (state)
      INIT: begin
        if (ptr == LAST) begin
          state_n = RUN;
          ready_n = 1'b1;
        end else begin
          ptr_n = ptr + 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_n = INIT;
          ptr_n   = '0;
          ready_n = 1'b0;
        end
      end
      default: begin
        state_n = INIT;
        ptr_n   = '0;
        ready_n = 1'b0;
      end
    endcase
  end

  // Array write: the sweep owns the array in INIT, the ports own it in RUN; no reset so it maps to RAM.
  always_ff @(posedge clk) begin
    if (rst && (state == INIT)) begin
      regs[ptr] <= '0;
    end else begin
      if (w1_go) begin
        regs[idx(waddr1)] <= wdata1;
      end
      if (w0_go) begin
        regs[idx(waddr0)] <= wdata0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] rd;

    // Combinational read with priority: gating, zero/out-of-range, port 1 bypass, port 0 bypass, array.
    always_comb begin
      a  = raddr[k*AW +: AW];
      rd = '0;
      if (!rst || !ready || !re[k]) begin
        rd = '0;
      end else if (!addr_ok(a)) begin
        rd = '0;
      end else if (w1_go && (waddr1 == a)) begin
        rd = wdata1;
      end else if (w0_go && (waddr0 == a)) begin
        rd = wdata0;
      end else begin
        rd = regs[idx(a)];
      end
    end

    assign rdata[k*DW +: DW] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp
module tb_regfile_mp;

  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 we0;
  logic [AW-1:0]        waddr0;
  logic [DW-1:0]        wdata0;
  logic                 we1;
  logic [AW-1:0]        waddr1;
  logic [DW-1:0]        wdata1;
  logic [NUM_RD-1:0]    re;
  logic [NUM_RD*AW-1:0] raddr;
  logic [NUM_RD*DW-1:0] rdata;
  logic [NUM_RD*DW-1:0] rdata_nz;
  logic                 clr_req;
  logic                 ready;
  logic                 ready_nz;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string         tag;
    int            port;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  regfile_mp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata),
    .clr_req(clr_req), .ready(ready)
  );

  regfile_mp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .re(re), .raddr(raddr), .rdata(rdata_nz),
    .clr_req(clr_req), .ready(ready_nz)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input int port, input logic [DW-1:0] exp, input string tag);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, rdata[e.port*DW +: DW], e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0     = 1'b0;
    we1     = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    rst    = 1'b0;
    idle();
    waddr0 = '0;
    waddr1 = '0;
    wdata0 = '0;
    wdata1 = '0;
    re     = 2'b11;
    raddr  = '0;

    // Reset state: ready low and reads forced to zero while rst is low.
    tick();
    tick();
    set_rd(5, 31);
    #3;
    expect_rd(0, '0, "rst_rd_p0");
    expect_rd(1, '0, "rst_rd_p1");
    drain();
    check("rst_ready", 32'(ready), 32'd0);

    // Release and count sweep edges: ready rises on edge 32 exactly.
    rst = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      check($sformatf("init_ready_e%0d", e), 32'(ready), (e == DEPTH) ? 32'd1 : 32'd0);
    end

    // Every entry reads zero on both ports after the sweep.
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(a));
      #3;
      expect_rd(0, '0, $sformatf("swept_p0_a%0d", a));
      expect_rd(1, '0, $sformatf("swept_p1_a%0d", a));
      drain();
      tick();
    end

    // Port 0 write with same-cycle bypass, then array read.
    we0 = 1'b1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    set_rd(5, 5);
    #3;
    expect_rd(0, 32'hDEADBEEF, "t2_bypass_p0");
    expect_rd(1, 32'hDEADBEEF, "t2_bypass_p1");
    drain();
    tick();
    idle();
    #3;
    expect_rd(0, 32'hDEADBEEF, "t2_array_p0");
    drain();

    // re[k]=0 forces that port to zero only.
    tick();
    re = 2'b10;
    #3;
    expect_rd(0, '0, "re0_p0");
    expect_rd(1, 32'hDEADBEEF, "re0_p1");
    drain();
    re = 2'b11;

    // Same-address collision: port 1 wins in bypass and in the array.
    tick();
    we0 = 1'b1; waddr0 = 7; wdata0 = 32'h1111;
    we1 = 1'b1; waddr1 = 7; wdata1 = 32'h2222;
    set_rd(7, 7);
    #3;
    expect_rd(0, 32'h2222, "t3_bypass_p0");
    expect_rd(1, 32'h2222, "t3_bypass_p1");
    drain();
    tick();
    idle();
    #3;
    expect_rd(0, 32'h2222, "t3_array_p0");
    drain();

    // Independent writes on both ports, including the last address.
    tick();
    we0 = 1'b1; waddr0 = 30; wdata0 = 32'h3030;
    we1 = 1'b1; waddr1 = 31; wdata1 = 32'hCAFE0031;
    set_rd(30, 31);
    #3;
    expect_rd(0, 32'h3030, "dual_bypass_p0");
    expect_rd(1, 32'hCAFE0031, "dual_bypass_p1");
    drain();
    tick();
    idle();
    #3;
    expect_rd(0, 32'h3030, "dual_array_p0");
    expect_rd(1, 32'hCAFE0031, "dual_array_p1");
    drain();

    // Address 0: hard-wired zero versus ordinary register.
    tick();
    we0 = 1'b1; waddr0 = 0; wdata0 = 32'hFFFF_FFFF;
    set_rd(0, 0);
    #3;
    expect_rd(0, '0, "t4_zr_bypass_p0");
    expect_rd(1, '0, "t4_zr_bypass_p1");
    drain();
    check("t4_nz_bypass", rdata_nz[DW-1:0], 32'hFFFF_FFFF);
    tick();
    idle();
    #3;
    expect_rd(0, '0, "t4_zr_array");
    drain();
    check("t4_nz_array", rdata_nz[DW-1:0], 32'hFFFF_FFFF);

    // Re-clear: fill address 9, then clr_req with a write to address 3.
    tick();
    we0 = 1'b1; waddr0 = 9; wdata0 = 32'hA5A5;
    tick();
    idle();
    set_rd(9, 3);
    #3;
    expect_rd(0, 32'hA5A5, "t5_fill9");
    drain();
    tick();
    clr_req = 1'b1;
    we0 = 1'b1; waddr0 = 3; wdata0 = 32'h3333;
    #3;
    check("t5_ready_before", 32'(ready), 32'd1);
    tick();
    check("t5_ready_fell", 32'(ready), 32'd0);
    // clr_req held during the first sweep edges must not restart it; a mid-sweep write must drop.
    for (int e = 1; e <= DEPTH; e++) begin
      clr_req = (e <= 10);
      we0     = (e == 20);
      waddr0  = 3;
      wdata0  = 32'h3333;
      set_rd(9, 9);
      #3;
      if (e == 15) begin
        expect_rd(0, '0, "t5_init_rd_p0");
        expect_rd(1, '0, "t5_init_rd_p1");
        drain();
      end
      tick();
      check($sformatf("t5_ready_e%0d", e), 32'(ready), (e == DEPTH) ? 32'd1 : 32'd0);
    end
    idle();
    set_rd(9, 3);
    #3;
    expect_rd(0, '0, "t5_addr9_cleared");
    expect_rd(1, '0, "t5_addr3_dropped");
    drain();

    // rst low while running forces reads to zero combinationally.
    tick();
    we0 = 1'b1; waddr0 = 31; wdata0 = 32'h12345678;
    tick();
    idle();
    set_rd(31, 31);
    #2;
    expect_rd(0, 32'h12345678, "t6_pre_rst");
    drain();
    rst = 1'b0;
    #2;
    expect_rd(0, '0, "t6_rst_low_p0");
    expect_rd(1, '0, "t6_rst_low_p1");
    drain();
    rst = 1'b1;

    // Reset mid-sweep: sweep restarts and ready rises 32 edges after release.
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    check("t6_ready_in_rst", 32'(ready), 32'd0);
    rst = 1'b1;
    for (int e = 1; e <= DEPTH; e++) begin
      tick();
      check($sformatf("t6_ready_e%0d", e), 32'(ready), (e == DEPTH) ? 32'd1 : 32'd0);
    end
    #3;
    expect_rd(0, '0, "t6_addr31_cleared_p0");
    expect_rd(1, '0, "t6_addr31_cleared_p1");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
